conv_stream_feeder: RTL and testbench

//  Sequencer that feeds the 3x3 convolver datapath. It is the producer side of the

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_addr_gen.sv | 66 ++++++
 rtl/conv_stream_feeder.sv | 150 +++++++++++++++
 tb/tb_conv_stream_feeder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Constants and state encoding shared by the convolver feeder and the convolver control.
package conv_pkg;

  localparam int         CONV_DATA_W = 8;
  localparam logic [3:0] KERNEL_N    = 4'd9;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_W = ST_LOAD_W,
    FETCH  = ST_FETCH,
    SHIFT  = ST_SHIFT,
    DONE   = ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Row-band / column / lane counters of the feeder and the buffer address they select.
module conv_addr_gen #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 8,
  parameter int W_BASE = 0,
  parameter int I_BASE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              lane_inc,
  input  logic              lane_clr,
  input  logic              col_adv,
  input  logic              wsel,
  output logic [3:0]        lane,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_band,
  output logic              col_ge2
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int BAND_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(IMG_H - 3);

  logic [COL_W-1:0]  col_reg;
  logic [BAND_W-1:0] band_reg;
  logic [3:0]        lane_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg  <= '0;
      band_reg <= '0;
      lane_reg <= '0;
    end else if (clr) begin
      col_reg  <= '0;
      band_reg <= '0;
      lane_reg <= '0;
    end else begin
      if (lane_clr)
        lane_reg <= '0;
      else if (lane_inc)
        lane_reg <= lane_reg + 4'd1;
      if (col_adv) begin
        if (col_reg == COL_LAST) begin
          col_reg  <= '0;
          band_reg <= band_reg + BAND_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
    end
  end

  // Lane doubles as weight index while loading and as row offset inside the band.
  assign addr = wsel ? ADDR_W'(W_BASE + int'(lane_reg))
                     : ADDR_W'(I_BASE + (int'(band_reg) + int'(lane_reg)) * IMG_W + int'(col_reg));

  assign lane      = lane_reg;
  assign last_col  = (col_reg == COL_LAST);
  assign last_band = (band_reg == BAND_LAST);
  assign col_ge2   = (col_reg >= COL_W'(2));

endmodule

// File: rtl/conv_stream_feeder.sv
// Sequencer feeding the 3x3 convolver: loads the 9 kernel weights, then streams
// 3-pixel image columns band by band and flags complete windows.
module conv_stream_feeder
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 8,
  parameter int W_BASE = 0,
  parameter int I_BASE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                weight_write,
  output logic [3:0]          weight_idx,
  output logic [DATA_W-1:0]   weight_data,
  output logic                three_shift,
  output logic [3*DATA_W-1:0] pix_col,
  input  logic                conv_ready,
  output logic                window_valid
);

  logic [2:0]        state_reg, state_next;
  logic [3:0]        lane;
  logic [ADDR_W-1:0] gen_addr;
  logic              last_col, last_band, col_ge2;
  logic              ctr_clr, lane_inc, lane_clr, col_adv;
  logic              rd_weight, rd_pix, fire;
  logic              wr_pend_reg;
  logic [3:0]        wr_idx_reg;
  logic              cap_valid_reg;
  logic [1:0]        cap_lane_reg;
  logic [DATA_W-1:0] col_reg [3];
  logic [DATA_W-1:0] lane2_pix;

  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .W_BASE(W_BASE),
    .I_BASE(I_BASE)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clr      (ctr_clr),
    .lane_inc (lane_inc),
    .lane_clr (lane_clr),
    .col_adv  (col_adv),
    .wsel     (state_reg == ST_LOAD_W),
    .lane     (lane),
    .addr     (gen_addr),
    .last_col (last_col),
    .last_band(last_band),
    .col_ge2  (col_ge2)
  );

  assign rd_weight    = (state_reg == ST_LOAD_W) && (lane < KERNEL_N);
  assign rd_pix       = (state_reg == ST_FETCH);
  assign mem_rd_en    = rd_weight | rd_pix;
  assign mem_addr     = mem_rd_en ? gen_addr : '0;
  assign three_shift  = (state_reg == ST_SHIFT);
  assign fire         = three_shift & conv_ready;
  assign window_valid = three_shift & col_ge2;
  assign busy         = (state_reg == ST_LOAD_W) || (state_reg == ST_FETCH) || (state_reg == ST_SHIFT);
  assign done         = (state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    ctr_clr    = 1'b0;
    lane_inc   = 1'b0;
    lane_clr   = 1'b0;
    col_adv    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD_W;
          ctr_clr    = 1'b1;
        end
      end
      ST_LOAD_W: begin
        // Extra cycle at lane 9 lets the last weight datum return before fetching.
        if (lane == KERNEL_N) begin
          state_next = ST_FETCH;
          lane_clr   = 1'b1;
        end else begin
          lane_inc = 1'b1;
        end
      end
      ST_FETCH: begin
        if (lane == 4'd2) begin
          state_next = ST_SHIFT;
          lane_clr   = 1'b1;
        end else begin
          lane_inc = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (fire) begin
          if (last_col && last_band) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_FETCH;
            col_adv    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        ctr_clr    = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wr_pend_reg   <= 1'b0;
      wr_idx_reg    <= '0;
      cap_valid_reg <= 1'b0;
      cap_lane_reg  <= '0;
      for (int i = 0; i < 3; i++)
        col_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      wr_pend_reg   <= rd_weight;
      wr_idx_reg    <= lane;
      cap_valid_reg <= rd_pix;
      cap_lane_reg  <= lane[1:0];
      if (cap_valid_reg)
        col_reg[cap_lane_reg] <= mem_rd_data;
    end
  end

  assign weight_write = wr_pend_reg;
  assign weight_idx   = wr_pend_reg ? wr_idx_reg : 4'd0;
  assign weight_data  = wr_pend_reg ? mem_rd_data : '0;

  // Lane 2 arrives in the first shift cycle; forward it so a column takes 4 cycles.
  assign lane2_pix = cap_valid_reg ? mem_rd_data : col_reg[2];
  assign pix_col   = three_shift ? {lane2_pix, col_reg[1], col_reg[0]} : '0;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder: a 4x4 and a 3x3 instance with buffer models.
module tb_conv_stream_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_drv, ready_drv, sel;
  int   errors = 0;
  int   checks = 0;

  logic        start4, busy4, done4, rd_en4, ww4, sh4, wv4;
  logic [7:0]  addr4, wdata4;
  logic [7:0]  rdata4 = '0;
  logic [3:0]  widx4;
  logic [23:0] pix4;
  logic        start3, busy3, done3, rd_en3, ww3, sh3, wv3;
  logic [7:0]  addr3, wdata3;
  logic [7:0]  rdata3 = '0;
  logic [3:0]  widx3;
  logic [23:0] pix3;
  logic [7:0]  mem4 [256];
  logic [7:0]  mem3 [256];

  assign start4 = start_drv & ~sel;
  assign start3 = start_drv & sel;

  conv_stream_feeder #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .ADDR_W(8), .W_BASE(0), .I_BASE(16)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
    .mem_rd_en(rd_en4), .mem_addr(addr4), .mem_rd_data(rdata4),
    .weight_write(ww4), .weight_idx(widx4), .weight_data(wdata4),
    .three_shift(sh4), .pix_col(pix4), .conv_ready(ready_drv), .window_valid(wv4));

  conv_stream_feeder #(.DATA_W(8), .IMG_W(3), .IMG_H(3), .ADDR_W(8), .W_BASE(0), .I_BASE(16)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3),
    .mem_rd_en(rd_en3), .mem_addr(addr3), .mem_rd_data(rdata3),
    .weight_write(ww3), .weight_idx(widx3), .weight_data(wdata3),
    .three_shift(sh3), .pix_col(pix3), .conv_ready(ready_drv), .window_valid(wv3));

  always @(posedge clk) if (rd_en4) rdata4 <= mem4[addr4];
  always @(posedge clk) if (rd_en3) rdata3 <= mem3[addr3];

  logic        o_busy, o_done, o_rd_en, o_ww, o_sh, o_wv;
  logic [3:0]  o_widx;
  logic [7:0]  o_wdata;
  logic [23:0] o_pix;
  assign o_busy  = sel ? busy3  : busy4;
  assign o_done  = sel ? done3  : done4;
  assign o_rd_en = sel ? rd_en3 : rd_en4;
  assign o_ww    = sel ? ww3    : ww4;
  assign o_sh    = sel ? sh3    : sh4;
  assign o_wv    = sel ? wv3    : wv4;
  assign o_widx  = sel ? widx3  : widx4;
  assign o_wdata = sel ? wdata3 : wdata4;
  assign o_pix   = sel ? pix3   : pix4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full job: start pulsed in the current (idle) cycle, returns at the done cycle.
  task automatic run(input string tag, input int img_w, input int img_h, input int stall_at,
                     input int stall_len, input int restart_at, input int exp_done,
                     input logic [7:0] exp_mask);
    int          w_cnt = 0, sh_cnt = 0, done_cnt = 0, stalled = 0, done_cyc = -1, first_sh = -1;
    int          b, c;
    logic [7:0]  mask = '0;
    logic [23:0] held = '0;
    logic        busy_ok = 1'b1, pix_stable = 1'b1, no_rd_stall = 1'b1, ww_late = 1'b0;
    logic [23:0] exp_pix;
    chk({tag, "_idle_busy"}, o_busy, 0);
    chk({tag, "_idle_done"}, o_done, 0);
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      start_drv = (cyc == restart_at);
      ready_drv = 1'b1;
      if (o_sh && sh_cnt == stall_at && stalled < stall_len) begin
        ready_drv = 1'b0;
        stalled++;
        if (stalled == 1) held = o_pix;
        else if (o_pix !== held) pix_stable = 1'b0;
        if (o_rd_en) no_rd_stall = 1'b0;
      end
      if (o_ww) begin
        $display("[%s] cyc %0d weight idx=%0d data=%0d", tag, cyc, o_widx, o_wdata);
        chk({tag, "_widx"}, o_widx, w_cnt);
        chk({tag, "_wdata"}, o_wdata, w_cnt + 1);
        if (sh_cnt > 0) ww_late = 1'b1;
        w_cnt++;
      end
      if (o_sh && ready_drv) begin
        if (first_sh < 0) first_sh = cyc;
        if (stall_len > 0 && sh_cnt == stall_at && o_pix !== held) pix_stable = 1'b0;
        b = sh_cnt / img_w;
        c = sh_cnt % img_w;
        exp_pix = {8'(10 * (b + 2) + c), 8'(10 * (b + 1) + c), 8'(10 * b + c)};
        $display("[%s] cyc %0d shift %0d pix=%h wv=%0d", tag, cyc, sh_cnt, o_pix, o_wv);
        chk({tag, "_pix"}, o_pix, exp_pix);
        if (o_wv) mask[sh_cnt] = 1'b1;
        sh_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk({tag, "_busy_in_done"}, o_busy, 0);
        break;
      end else if (o_busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      tick();
    end
    start_drv = 1'b0;
    ready_drv = 1'b1;
    $display("[%s] done at cyc %0d shifts=%0d", tag, done_cyc, sh_cnt);
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_weights"}, w_cnt, 9);
    chk({tag, "_shifts"}, sh_cnt, img_w * (img_h - 2));
    chk({tag, "_wv_mask"}, mask, exp_mask);
    chk({tag, "_first_shift"}, first_sh, 14);
    chk({tag, "_busy_held"}, busy_ok, 1);
    chk({tag, "_ww_in_stream"}, ww_late, 0);
    if (stall_len > 0) begin
      chk({tag, "_stall_cycles"}, stalled, stall_len);
      chk({tag, "_pix_stable"}, pix_stable, 1);
      chk({tag, "_no_rd_stall"}, no_rd_stall, 1);
    end
  endtask

  initial begin
    logic found, quiet;
    reset = 1'b1; start_drv = 1'b0; ready_drv = 1'b1; sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem4[i] = '0;
      mem3[i] = '0;
    end
    for (int k = 0; k < 9; k++) begin
      mem4[k] = 8'(k + 1);
      mem3[k] = 8'(k + 1);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mem4[16 + r * 4 + c] = 8'(10 * r + c);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mem3[16 + r * 3 + c] = 8'(10 * r + c);

    tick(); tick();
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_rd_en4", rd_en4, 0);
    chk("rst_addr4", addr4, 0);
    chk("rst_ww4", ww4, 0);
    chk("rst_shift4", sh4, 0);
    chk("rst_pix4", pix4, 0);
    chk("rst_wv4", wv4, 0);
    chk("rst_busy3", busy3, 0);
    reset = 1'b0;
    tick();

    run("base4", 4, 4, -1, 0, -1, 43, 8'hCC);
    tick();
    run("stall4", 4, 4, 2, 5, -1, 48, 8'hCC);
    tick();
    run("restart4", 4, 4, -1, 0, 20, 43, 8'hCC);

    // Abort while weight 4 is being written.
    tick();
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ww4 && widx4 == 4'd4) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reach_w4", found, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_ww", ww4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_rd_en", rd_en4, 0);
    chk("abort_widx", widx4, 0);
    chk("abort_wdata", wdata4, 0);
    tick(); tick();
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4 || busy4) quiet = 1'b0;
    end
    chk("abort_no_done", quiet, 1);
    run("reload4", 4, 4, -1, 0, -1, 43, 8'hCC);

    sel = 1'b1;
    tick();
    run("img3a", 3, 3, -1, 0, -1, 23, 8'h04);
    tick();
    run("img3b", 3, 3, -1, 0, -1, 23, 8'h04);
    tick();
    chk("img3_final_idle", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
